// File: rtl/synthesijer_div_pkg.sv
// Shared types and helpers for the Synthesijer sequential divider.
package synthesijer_div_pkg;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } div_state_t;

    // Widest operand the helper functions can handle
    localparam int MAX_W = 128;

    // True when the WIDTH / STEPS_PER_CYCLE pair is a supported configuration
    function automatic bit steps_legal(input int width, input int steps);
        return (width >= 4) && (width <= MAX_W) && ((width % 2) == 0) &&
               ((steps == 1) || (steps == 2) || (steps == 4)) &&
               ((width % steps) == 0);
    endfunction

    // Mask selecting the low 'width' bits
    function automatic logic [MAX_W-1:0] width_mask(input int width);
        return {MAX_W{1'b1}} >> (MAX_W - width);
    endfunction

    // Two's-complement negation modulo 2^width
    function automatic logic [MAX_W-1:0] negate(input logic [MAX_W-1:0] v, input int width);
        return (~v + {{(MAX_W-1){1'b0}}, 1'b1}) & width_mask(width);
    endfunction

    // Magnitude of a value whose sign has already been decided by the caller
    function automatic logic [MAX_W-1:0] magnitude(input logic [MAX_W-1:0] v, input int width,
                                                   input logic is_neg);
        logic [MAX_W-1:0] r;
        if (is_neg) begin
            r = negate(v, width);
        end else begin
            r = v & width_mask(width);
        end
        return r;
    endfunction

endpackage

// File: rtl/synthesijer_div_step.sv
// One combinational radix-2 restoring division step.
module synthesijer_div_step
    import synthesijer_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] trial_s;

    // Shift the next dividend bit in, trial-subtract, keep the result if it did not borrow
    always_comb begin
        shifted_s = {rem_in, quo_in[WIDTH-1]};
        trial_s   = shifted_s - {2'b00, divisor};
        if (trial_s[WIDTH+1] == 1'b0) begin
            rem_out = trial_s[WIDTH:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out = shifted_s[WIDTH:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/synthesijer_div_seq.sv
// Sequential integer divider with Java truncating semantics, ready/valid handshake
// and a configurable number of restoring steps per clock.
module synthesijer_div_seq
    import synthesijer_div_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             nd,
    output logic             ready,
    output logic [WIDTH-1:0] quantient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid,
    output logic             div_by_zero
);

    localparam int D     = WIDTH / STEPS_PER_CYCLE;
    localparam int CNT_W = $clog2(D + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(D - 1);
    localparam bit CFG_OK = steps_legal(WIDTH, STEPS_PER_CYCLE);

    if (!CFG_OK) begin : g_cfg_check
        $error("synthesijer_div_seq: unsupported WIDTH/STEPS_PER_CYCLE combination");
    end

    div_state_t       state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             sgn_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] div_r;
    logic             qneg_r;
    logic             rneg_r;
    logic             bz_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ready_r;
    logic             valid_r;
    logic             dbz_r;
    logic [WIDTH-1:0] quant_r;
    logic [WIDTH-1:0] remd_r;

    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic [WIDTH-1:0] quo_fix_s;
    logic [WIDTH-1:0] rem_fix_s;
    logic [WIDTH:0]   rem_next_s;
    logic [WIDTH-1:0] quo_next_s;

    // Operand magnitudes and sign-corrected results
    always_comb begin
        a_neg_s = sgn_r & a_r[WIDTH-1];
        b_neg_s = sgn_r & b_r[WIDTH-1];
        mag_a_s = WIDTH'(magnitude(MAX_W'(a_r), WIDTH, a_neg_s));
        mag_b_s = WIDTH'(magnitude(MAX_W'(b_r), WIDTH, b_neg_s));
        if (qneg_r) begin
            quo_fix_s = WIDTH'(negate(MAX_W'(quo_r), WIDTH));
        end else begin
            quo_fix_s = quo_r;
        end
        if (rneg_r) begin
            rem_fix_s = WIDTH'(negate(MAX_W'(rem_r[WIDTH-1:0]), WIDTH));
        end else begin
            rem_fix_s = rem_r[WIDTH-1:0];
        end
    end

    // Chain of restoring steps evaluated each DIV clock
    for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
        logic [WIDTH:0]   rem_in_s;
        logic [WIDTH-1:0] quo_in_s;
        logic [WIDTH:0]   rem_out_s;
        logic [WIDTH-1:0] quo_out_s;

        if (g == 0) begin : g_first
            assign rem_in_s = rem_r;
            assign quo_in_s = quo_r;
        end else begin : g_next
            assign rem_in_s = g_step[g-1].rem_out_s;
            assign quo_in_s = g_step[g-1].quo_out_s;
        end

        synthesijer_div_step #(
            .WIDTH(WIDTH)
        ) u_step (
            .rem_in (rem_in_s),
            .quo_in (quo_in_s),
            .divisor(div_r),
            .rem_out(rem_out_s),
            .quo_out(quo_out_s)
        );
    end

    assign rem_next_s = g_step[STEPS_PER_CYCLE-1].rem_out_s;
    assign quo_next_s = g_step[STEPS_PER_CYCLE-1].quo_out_s;

    // Control FSM, iteration datapath and registered results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            sgn_r   <= 1'b0;
            quo_r   <= {WIDTH{1'b0}};
            rem_r   <= {(WIDTH+1){1'b0}};
            div_r   <= {WIDTH{1'b0}};
            qneg_r  <= 1'b0;
            rneg_r  <= 1'b0;
            bz_r    <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            dbz_r   <= 1'b0;
            quant_r <= {WIDTH{1'b0}};
            remd_r  <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    valid_r <= 1'b0;
                    if (nd) begin
                        a_r     <= a;
                        b_r     <= b;
                        sgn_r   <= is_signed;
                        ready_r <= 1'b0;
                        state_r <= PREP;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                PREP: begin
                    quo_r   <= mag_a_s;
                    div_r   <= mag_b_s;
                    qneg_r  <= a_neg_s ^ b_neg_s;
                    rneg_r  <= a_neg_s;
                    bz_r    <= (b_r == {WIDTH{1'b0}});
                    rem_r   <= {(WIDTH+1){1'b0}};
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= DIV;
                end
                DIV: begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_LAST) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= DIV;
                    end
                end
                FIX: begin
                    if (bz_r) begin
                        quant_r <= {WIDTH{1'b1}};
                        remd_r  <= a_r;
                        dbz_r   <= 1'b1;
                    end else begin
                        quant_r <= quo_fix_s;
                        remd_r  <= rem_fix_s;
                        dbz_r   <= 1'b0;
                    end
                    valid_r <= 1'b1;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign ready       = ready_r;
    assign valid       = valid_r;
    assign div_by_zero = dbz_r;
    assign quantient   = quant_r;
    assign remainder   = remd_r;

endmodule
